// File: rtl/ks_addsub_pipe_if.sv
// Operand/result handshake bundle for the Kogge-Stone add/sub pipeline.
// Master drives operands and out_ready; slave is the adder.
interface ks_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/ks_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, one prefix level per stage.
// Sum XOR and flags are formed in the last stage; whole pipe stalls together.
module ks_addsub_pipe #(
    parameter  int WIDTH  = 16,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst,
    ks_addsub_pipe_if.slave io
);
    logic             adv;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic             c0;

    logic [WIDTH-1:0] g_q    [1:LEVELS-1];
    logic [WIDTH-1:0] p_q    [1:LEVELS-1];
    logic [WIDTH-1:0] praw_q [1:LEVELS-1];
    logic             c0_q   [1:LEVELS-1];
    logic             vld_q  [1:LEVELS-1];

    logic [WIDTH-1:0] g_in    [0:LEVELS-1];
    logic [WIDTH-1:0] p_in    [0:LEVELS-1];
    logic [WIDTH-1:0] praw_in [0:LEVELS-1];
    logic             c0_in   [0:LEVELS-1];

    logic [WIDTH-1:0] g_nx [1:LEVELS];
    logic [WIDTH-1:0] p_nx [1:LEVELS-1];

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_nx;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign adv          = ~out_valid_q | io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;
    assign io.zero      = zero_q;

    // Operand conditioning, bit P/G, and carry-in merged into bit 0.
    always_comb begin
        bx    = io.sub ? ~io.b : io.b;
        c0    = io.sub | io.cin;
        p0    = io.a ^ bx;
        g0    = io.a & bx;
        g0[0] = g0[0] | (p0[0] & c0);
    end

    // Stage inputs: level 1 reads stage 0, later levels read the registers.
    always_comb begin
        g_in[0]    = g0;
        p_in[0]    = p0;
        praw_in[0] = p0;
        c0_in[0]   = c0;
        for (int k = 1; k < LEVELS; k++) begin
            g_in[k]    = g_q[k];
            p_in[k]    = p_q[k];
            praw_in[k] = praw_q[k];
            c0_in[k]   = c0_q[k];
        end
    end

    // Prefix levels: black cells far out, gray cells next, buffers below d.
    always_comb begin
        for (int k = 1; k <= LEVELS; k++) begin
            g_nx[k] = g_in[k-1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << (k-1))) begin
                    g_nx[k][i] = g_in[k-1][i]
                               | (p_in[k-1][i] & g_in[k-1][i-(1<<(k-1))]);
                end
            end
        end
        for (int k = 1; k < LEVELS; k++) begin
            p_nx[k] = p_in[k-1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (2 << (k-1))) begin
                    p_nx[k][i] = p_in[k-1][i]
                               & p_in[k-1][i-(1<<(k-1))];
                end else if (i >= (1 << (k-1))) begin
                    p_nx[k][i] = 1'b0;
                end
            end
        end
    end

    // Final carries come straight out of the last prefix level.
    always_comb begin
        carry  = {g_nx[LEVELS][WIDTH-2:0], c0_in[LEVELS-1]};
        sum_nx = praw_in[LEVELS-1] ^ carry;
    end

    // Pipeline registers: everything shifts together on adv, reset clears valids and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < LEVELS; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            vld_q[1] <= io.in_valid;
            for (int k = 2; k < LEVELS; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 1; k < LEVELS; k++) begin
                g_q[k]    <= g_nx[k];
                p_q[k]    <= p_nx[k];
                praw_q[k] <= praw_in[k-1];
                c0_q[k]   <= c0_in[k-1];
            end
            out_valid_q <= vld_q[LEVELS-1];
            sum_q       <= sum_nx;
            cout_q      <= g_nx[LEVELS][WIDTH-1];
            ovf_q       <= carry[WIDTH-1] ^ g_nx[LEVELS][WIDTH-1];
            zero_q      <= ~|sum_nx;
        end
    end
endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Bench for ks_addsub_pipe: directed corners plus random streams
// checked against an integer-arithmetic reference queue.
module tb_ks_addsub_pipe;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    res_t q[$];

    always #5 clk = ~clk;

    ks_addsub_pipe_if #(.WIDTH(W)) io();

    ks_addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic cin, logic sub);
        res_t         r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.o  = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
        r.z  = (r.s == '0);
        return r;
    endfunction

    task automatic rand_ops();
        io.a   = W'($urandom);
        io.b   = W'($urandom);
        io.cin = 1'($urandom);
        io.sub = ($urandom_range(3) == 0);
    endtask

    // One clock: sample at negedge, track model, return at posedge+1.
    task automatic tick(output bit acc, output bit fired, output bit ov,
                        output bit ir, output res_t got, output res_t exp,
                        output bit have);
        @(negedge clk);
        ov    = io.out_valid;
        ir    = io.in_ready;
        got   = {io.sum, io.cout, io.ovf, io.zero};
        acc   = io.in_valid && io.in_ready;
        fired = io.out_valid && io.out_ready;
        have  = 1'b0;
        exp   = '0;
        if (fired && q.size() > 0) begin
            exp  = q.pop_front();
            have = 1'b1;
        end
        if (acc) q.push_back(model(io.a, io.b, io.cin, io.sub));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (io.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b want=0", io.out_valid);
        end
        checks++;
        if (io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", io.in_ready);
        end
        checks++;
        if ({io.sum, io.cout, io.ovf, io.zero} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {io.sum, io.cout, io.ovf, io.zero});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         tc [5];
        logic         ts [5];
        res_t         te [5];
        int           lat;
        res_t         got;
        ta[0] = 16'h1234; tb[0] = 16'h4321; tc[0] = 0; ts[0] = 0;
        te[0] = {16'h5555, 1'b0, 1'b0, 1'b0};
        ta[1] = 16'hFFFF; tb[1] = 16'h0001; tc[1] = 0; ts[1] = 0;
        te[1] = {16'h0000, 1'b1, 1'b0, 1'b1};
        ta[2] = 16'h7FFF; tb[2] = 16'h0001; tc[2] = 0; ts[2] = 0;
        te[2] = {16'h8000, 1'b0, 1'b1, 1'b0};
        ta[3] = 16'h0005; tb[3] = 16'h0007; tc[3] = 0; ts[3] = 1;
        te[3] = {16'hFFFE, 1'b0, 1'b0, 1'b0};
        ta[4] = 16'hABCD; tb[4] = 16'hABCD; tc[4] = 1; ts[4] = 1;
        te[4] = {16'h0000, 1'b1, 1'b0, 1'b1};
        io.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            io.a = ta[n]; io.b = tb[n]; io.cin = tc[n]; io.sub = ts[n];
            io.in_valid = 1'b1;
            @(posedge clk);
            #1;
            io.in_valid = 1'b0;
            lat = 1;
            while (!io.out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            got = {io.sum, io.cout, io.ovf, io.zero};
            checks++;
            if (lat != 4) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d want=4", n, lat);
            end
            checks++;
            if (got !== te[n]) begin
                failures++;
                $display("FAIL dir%0d_result got=%h want=%h", n, got, te[n]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit   acc, fired, ov, ir, have, iv;
        res_t got, exp;
        int   issued = 0, n_out = 0, cyc = 0, first = -1, last = -1;
        q.delete();
        io.out_ready = 1'b1;
        while ((issued < 32 || q.size() > 0) && cyc < 200) begin
            iv = (issued < 32);
            io.in_valid = iv;
            rand_ops();
            tick(acc, fired, ov, ir, got, exp, have);
            if (acc) issued++;
            if (iv) begin
                checks++;
                if (!ir) begin
                    failures++;
                    $display("FAIL b2b_in_ready cyc=%0d got=0 want=1", cyc);
                end
            end
            if (fired) begin
                checks++;
                if (!have || got !== exp) begin
                    failures++;
                    $display("FAIL b2b_result cyc=%0d got=%h want=%h",
                             cyc, got, exp);
                end
                n_out++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            cyc++;
        end
        io.in_valid = 1'b0;
        checks++;
        if (n_out != 32) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=32", n_out);
        end
        checks++;
        if (last - first != 31) begin
            failures++;
            $display("FAIL b2b_throughput got=%0d want=31", last - first);
        end
    endtask

    task automatic test_stall();
        bit   acc, fired, ov, ir, have, pstall = 0;
        res_t got, exp, prev = '0;
        int   issued = 0, n_out = 0, cyc = 0;
        q.delete();
        while ((issued < 20 || q.size() > 0) && cyc < 200) begin
            io.in_valid  = (issued < 20);
            io.out_ready = !(cyc >= 6 && cyc < 12);
            rand_ops();
            tick(acc, fired, ov, ir, got, exp, have);
            if (acc) issued++;
            if (ov && !io.out_ready) begin
                checks++;
                if (ir !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready cyc=%0d got=1 want=0", cyc);
                end
                if (pstall) begin
                    checks++;
                    if (got !== prev) begin
                        failures++;
                        $display("FAIL stall_hold cyc=%0d got=%h want=%h",
                                 cyc, got, prev);
                    end
                end
                prev   = got;
                pstall = 1'b1;
            end else begin
                pstall = 1'b0;
            end
            if (fired) begin
                checks++;
                if (!have || got !== exp) begin
                    failures++;
                    $display("FAIL stall_result cyc=%0d got=%h want=%h",
                             cyc, got, exp);
                end
                n_out++;
            end
            cyc++;
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        checks++;
        if (n_out != 20) begin
            failures++;
            $display("FAIL stall_count got=%0d want=20", n_out);
        end
    endtask

    task automatic test_reset_flush();
        bit   acc, fired, ov, ir, have, seen = 0;
        res_t got, exp;
        int   n_out = 0;
        q.delete();
        io.out_ready = 1'b1;
        repeat (3) begin
            io.in_valid = 1'b1;
            rand_ops();
            tick(acc, fired, ov, ir, got, exp, have);
        end
        io.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        checks++;
        if (io.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_out_valid got=%b want=0", io.out_valid);
        end
        checks++;
        if (io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_in_ready got=%b want=1", io.in_ready);
        end
        repeat (10) begin
            tick(acc, fired, ov, ir, got, exp, have);
            if (ov) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL flush_ghost got=1 want=0");
        end
        io.in_valid = 1'b1;
        rand_ops();
        tick(acc, fired, ov, ir, got, exp, have);
        io.in_valid = 1'b0;
        repeat (8) begin
            tick(acc, fired, ov, ir, got, exp, have);
            if (fired) begin
                n_out++;
                checks++;
                if (!have || got !== exp) begin
                    failures++;
                    $display("FAIL flush_after got=%h want=%h", got, exp);
                end
            end
        end
        checks++;
        if (n_out != 1) begin
            failures++;
            $display("FAIL flush_after_count got=%0d want=1", n_out);
        end
    endtask

    initial begin
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.a         = '0;
        io.b         = '0;
        io.cin       = 1'b0;
        io.sub       = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
